// File: rtl/lvds_rx_pkg.sv
// Shared definitions for the 2-lane LVDS frame link.
// Holds the receiver state encoding, the default word/frame geometry used by
// both the TX generator and the receiver, and the pair-counter width helper.
package lvds_rx_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRecv
  } rx_state_e;

  localparam int unsigned DefWordW    = 16;
  localparam int unsigned DefFrameLen = 256;

  // Width of the counter that walks the WORD_W/2 bit-pairs of one word.
  function automatic int unsigned bit_cnt_w(input int unsigned word_w);
    return (word_w / 2 > 1) ? $clog2(word_w / 2) : 1;
  endfunction

endpackage

// File: rtl/lvds_rx_outreg.sv
// Single-entry valid/ready holding register for assembled words.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   load_i            a word completed this cycle
//   data_i, last_i    the completed word and its frame-last flag
//   ready_i           downstream ready
//   data_o, valid_o, last_o  registered stream output
//   ovf_o             one-cycle pulse: a completed word found the entry full
module lvds_rx_outreg #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic             last_o,
  output logic             ovf_o
);

  logic [Width-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;
  logic             free;

  // The entry can take a new word if it is empty or being drained this edge.
  assign free = !valid_q || ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    ovf_d   = 1'b0;
    if (load_i) begin
      if (free) begin
        data_d  = data_i;
        last_d  = last_i;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/lvds_frame_rx.sv
// Receive side of the 2-lane LVDS data link.
// Aligns frames on sync_in, packs MSB-first lane bit-pairs into WORD_W-bit
// words, and presents them on a valid/ready stream with frame-last marking.
// Ports:
//   clk, reset_n        capture clock, asynchronous active-low reset
//   sync_in             marks the first bit-pair of a frame
//   lane_in[1:0]        captured lane bits, lane_in[1] is the pair MSB
//   m_data/m_valid/m_last/m_ready  output word stream
//   err_sync            one-cycle pulse: sync arrived mid-frame
//   err_ovf             one-cycle pulse: a completed word was dropped
//   frame_cnt           completed frames, wraps
module lvds_frame_rx
  import lvds_rx_pkg::*;
#(
  parameter int unsigned WORD_W    = DefWordW,
  parameter int unsigned FRAME_LEN = DefFrameLen,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sync_in,
  input  logic [1:0]        lane_in,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              err_sync,
  output logic              err_ovf,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned BcW = bit_cnt_w(WORD_W);
  localparam int unsigned WcW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BcW-1:0] BitLast  = BcW'(WORD_W / 2 - 1);
  localparam logic [WcW-1:0] WordLast = WcW'(FRAME_LEN - 1);

  rx_state_e         state_q, state_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [BcW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WcW-1:0]    word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              err_sync_q, err_sync_d;
  logic              word_done;
  logic              word_last;
  logic              unused_sh_top;

  // The oldest pair is shifted out on every word; it is never observed.
  assign unused_sh_top = ^sh_q[WORD_W-1 -: 2];

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_sync_d  = 1'b0;
    word_done   = 1'b0;
    word_last   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sync_in) begin
          sh_d       = {sh_q[WORD_W-3:0], lane_in};
          bit_cnt_d  = BcW'(1);
          word_cnt_d = '0;
          state_d    = StRecv;
        end
      end
      StRecv: begin
        sh_d = {sh_q[WORD_W-3:0], lane_in};
        if (sync_in) begin
          // Frame restarts from this pair; the partial word is abandoned.
          err_sync_d = 1'b1;
          bit_cnt_d  = BcW'(1);
          word_cnt_d = '0;
        end else if (bit_cnt_q == BitLast) begin
          word_done = 1'b1;
          bit_cnt_d = '0;
          if (word_cnt_q == WordLast) begin
            // Frame completes even if the outreg drops this last word.
            word_last   = 1'b1;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            state_d     = StIdle;
          end else begin
            word_cnt_d = word_cnt_q + WcW'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BcW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      frame_cnt_q <= '0;
      err_sync_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_sync_q  <= err_sync_d;
    end
  end

  lvds_rx_outreg #(
    .Width (WORD_W)
  ) u_outreg (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .load_i  (word_done),
    .data_i  (sh_d),
    .last_i  (word_last),
    .ready_i (m_ready),
    .data_o  (m_data),
    .valid_o (m_valid),
    .last_o  (m_last),
    .ovf_o   (err_ovf)
  );

  assign err_sync  = err_sync_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_lvds_frame_rx.sv
// Directed self-checking bench for lvds_frame_rx with WORD_W=16, FRAME_LEN=4.
module tb_lvds_frame_rx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sync_in;
  logic [1:0]  lane_in;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        err_sync;
  logic        err_ovf;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  int exp_fc = 0;

  // Beats accepted downstream and error pulses seen, collected on the falling edge.
  logic [15:0] q_data[$];
  logic        q_last[$];
  int          n_sync = 0;
  int          n_ovf  = 0;

  always #5 clk = ~clk;

  lvds_frame_rx #(
    .WORD_W    (16),
    .FRAME_LEN (4),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sync_in   (sync_in),
    .lane_in   (lane_in),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .err_sync  (err_sync),
    .err_ovf   (err_ovf),
    .frame_cnt (frame_cnt)
  );

  always @(negedge clk) begin
    if (reset_n) begin
      if (m_valid && m_ready) begin
        q_data.push_back(m_data);
        q_last.push_back(m_last);
      end
      if (err_sync) n_sync++;
      if (err_ovf) n_ovf++;
    end
  end

  task automatic clear_mon();
    q_data.delete();
    q_last.delete();
    n_sync = 0;
    n_ovf  = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives npairs MSB-first pairs of w, sync on the first pair when first=1.
  task automatic send_word(input logic [15:0] w, input bit first, input int npairs);
    for (int i = 0; i < npairs; i++) begin
      sync_in = first && (i == 0);
      lane_in = w[15-2*i -: 2];
      @(posedge clk);
      #1;
    end
    sync_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sync_in = 1'b0;
    lane_in = 2'b00;
    m_ready = 1'b1;
    idle(2);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", m_valid); end
    total++; if (m_data !== 16'h0) begin bad++; $display("FAIL rst_data got=%h want=0000", m_data); end
    total++; if (m_last !== 1'b0) begin bad++; $display("FAIL rst_last got=%b want=0", m_last); end
    total++; if ({err_sync, err_ovf} !== 2'b00) begin
      bad++; $display("FAIL rst_err got=%b want=00", {err_sync, err_ovf});
    end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_fcnt got=%0d want=0", frame_cnt); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    logic [15:0] w[4] = '{16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001};
    clear_mon();
    for (int k = 0; k < 4; k++) send_word(w[k], k == 0, 8);
    idle(4);
    exp_fc = 1;
    total++; if (q_data.size() !== 4) begin
      bad++; $display("FAIL basic_count got=%0d want=4", q_data.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++; if (q_data[k] !== w[k]) begin
          bad++; $display("FAIL basic_data[%0d] got=%h want=%h", k, q_data[k], w[k]);
        end
        total++; if (q_last[k] !== (k == 3)) begin
          bad++; $display("FAIL basic_last[%0d] got=%b want=%b", k, q_last[k], k == 3);
        end
      end
    end
    total++; if (frame_cnt !== 16'(exp_fc)) begin
      bad++; $display("FAIL basic_fcnt got=%0d want=%0d", frame_cnt, exp_fc);
    end
    total++; if (n_sync + n_ovf !== 0) begin
      bad++; $display("FAIL basic_err got sync=%0d ovf=%0d want 0/0", n_sync, n_ovf);
    end
  endtask

  task automatic test_idle_noise();
    clear_mon();
    for (int i = 0; i < 50; i++) begin
      sync_in = 1'b0;
      lane_in = 2'(i);
      @(posedge clk);
      #1;
    end
    lane_in = 2'b00;
    total++; if (q_data.size() !== 0 || m_valid !== 1'b0) begin
      bad++; $display("FAIL idle_valid got beats=%0d valid=%b want 0/0", q_data.size(), m_valid);
    end
    total++; if (n_sync + n_ovf !== 0) begin
      bad++; $display("FAIL idle_err got sync=%0d ovf=%0d want 0/0", n_sync, n_ovf);
    end
    total++; if (frame_cnt !== 16'(exp_fc)) begin
      bad++; $display("FAIL idle_fcnt got=%0d want=%0d", frame_cnt, exp_fc);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[8] = '{16'h0F0F, 16'hF0F0, 16'h8001, 16'h7FFE,
                          16'hDEAD, 16'hBEEF, 16'h5555, 16'hAAAA};
    clear_mon();
    for (int k = 0; k < 8; k++) send_word(w[k], (k % 4) == 0, 8);
    idle(4);
    exp_fc = exp_fc + 2;
    total++; if (q_data.size() !== 8) begin
      bad++; $display("FAIL b2b_count got=%0d want=8", q_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        total++; if (q_data[k] !== w[k] || q_last[k] !== ((k % 4) == 3)) begin
          bad++; $display("FAIL b2b_word[%0d] got=%h/%b want=%h/%b", k, q_data[k], q_last[k],
                          w[k], (k % 4) == 3);
        end
      end
    end
    total++; if (frame_cnt !== 16'(exp_fc)) begin
      bad++; $display("FAIL b2b_fcnt got=%0d want=%0d", frame_cnt, exp_fc);
    end
    total++; if (n_sync !== 0) begin bad++; $display("FAIL b2b_sync got=%0d want=0", n_sync); end
  endtask

  task automatic test_sync_error();
    logic [15:0] w[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] e[5] = '{16'hC0DE, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
    clear_mon();
    send_word(16'hC0DE, 1'b1, 8);
    send_word(16'h9999, 1'b0, 3);
    for (int k = 0; k < 4; k++) send_word(w[k], k == 0, 8);
    idle(4);
    exp_fc = exp_fc + 1;
    total++; if (n_sync !== 1) begin bad++; $display("FAIL syncerr_pulses got=%0d want=1", n_sync); end
    total++; if (q_data.size() !== 5) begin
      bad++; $display("FAIL syncerr_count got=%0d want=5", q_data.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++; if (q_data[k] !== e[k] || q_last[k] !== (k == 4)) begin
          bad++; $display("FAIL syncerr_word[%0d] got=%h/%b want=%h/%b", k, q_data[k], q_last[k],
                          e[k], k == 4);
        end
      end
    end
    total++; if (frame_cnt !== 16'(exp_fc)) begin
      bad++; $display("FAIL syncerr_fcnt got=%0d want=%0d", frame_cnt, exp_fc);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] w[4] = '{16'hABCD, 16'h0BAD, 16'hCAFE, 16'hF00D};
    logic [15:0] e[3] = '{16'hABCD, 16'hCAFE, 16'hF00D};
    clear_mon();
    m_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send_word(w[k], k == 0, 8);
      end
      begin
        int waited = 0;
        while (m_valid !== 1'b1 && waited < 40) begin
          @(posedge clk);
          #1;
          waited++;
        end
        total++; if (m_valid !== 1'b1) begin
          bad++; $display("FAIL bp_first_valid got=%b want=1 within 40 cycles", m_valid);
        end
        for (int c = 0; c < 12; c++) begin
          total++; if (m_valid !== 1'b1 || m_data !== w[0] || m_last !== 1'b0) begin
            bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%b want=1/%h/0", c, m_valid, m_data,
                            m_last, w[0]);
          end
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
    join
    idle(4);
    exp_fc = exp_fc + 1;
    total++; if (n_ovf !== 1) begin bad++; $display("FAIL bp_ovf got=%0d want=1", n_ovf); end
    total++; if (q_data.size() !== 3) begin
      bad++; $display("FAIL bp_count got=%0d want=3", q_data.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++; if (q_data[k] !== e[k] || q_last[k] !== (k == 2)) begin
          bad++; $display("FAIL bp_word[%0d] got=%h/%b want=%h/%b", k, q_data[k], q_last[k],
                          e[k], k == 2);
        end
      end
    end
    total++; if (frame_cnt !== 16'(exp_fc)) begin
      bad++; $display("FAIL bp_fcnt got=%0d want=%0d", frame_cnt, exp_fc);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w[4] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    m_ready = 1'b0;
    send_word(16'h7777, 1'b1, 8);
    send_word(16'h8888, 1'b0, 8);
    send_word(16'h9999, 1'b0, 3);
    total++; if (m_valid !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre_valid got=%b want=1", m_valid);
    end
    reset_n = 1'b0;
    #1;
    total++; if (m_valid !== 1'b0 || frame_cnt !== 16'd0) begin
      bad++; $display("FAIL rstmid_async got valid=%b fcnt=%0d want 0/0", m_valid, frame_cnt);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_ready = 1'b1;
    exp_fc = 0;
    idle(2);
    clear_mon();
    for (int k = 0; k < 4; k++) send_word(w[k], k == 0, 8);
    idle(4);
    exp_fc = 1;
    total++; if (q_data.size() !== 4) begin
      bad++; $display("FAIL rstmid_count got=%0d want=4", q_data.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++; if (q_data[k] !== w[k] || q_last[k] !== (k == 3)) begin
          bad++; $display("FAIL rstmid_word[%0d] got=%h/%b want=%h/%b", k, q_data[k], q_last[k],
                          w[k], k == 3);
        end
      end
    end
    total++; if (frame_cnt !== 16'(exp_fc) || n_sync + n_ovf !== 0) begin
      bad++; $display("FAIL rstmid_after got fcnt=%0d sync=%0d ovf=%0d want %0d/0/0", frame_cnt,
                      n_sync, n_ovf, exp_fc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_noise();
    test_back_to_back();
    test_sync_error();
    test_backpressure();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
